// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle controller.
// LEGV8_IMM_OPS_EN adds the EX_I state used by ADDI/SUBI.
package legv8_ctrl_pkg;

    localparam int unsigned OPC_W = 11;
    localparam int unsigned ALU_W = 2;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExR,
        StExAddr,
        StMemLd,
        StMemSt,
        StWbR,
        StWbLd,
        StBrCbz,
        StBrB,
        StHalt
`ifdef LEGV8_IMM_OPS_EN
        , StExI
`endif
    } state_e;

    typedef enum logic [2:0] {ClsR, ClsLd, ClsSt, ClsCbz, ClsB, ClsImm, ClsIll} opc_class_e;

    typedef enum logic [1:0] {
        FaultNone    = 2'b00,
        FaultIllegal = 2'b01,
        FaultTimeout = 2'b10
    } fault_e;

    localparam logic [ALU_W-1:0] AluAdd   = 2'b00;
    localparam logic [ALU_W-1:0] AluPassB = 2'b01;
    localparam logic [ALU_W-1:0] AluFunct = 2'b10;

    // Don't-care bits are cleared in the mask; match holds the fixed bits.
    localparam logic [OPC_W-1:0] MaskR     = 11'b100_1111_0111;
    localparam logic [OPC_W-1:0] MatchR    = 11'b100_0101_0000;
    localparam logic [OPC_W-1:0] OpcLdur   = 11'b111_1100_0010;
    localparam logic [OPC_W-1:0] OpcStur   = 11'b111_1100_0000;
    localparam logic [OPC_W-1:0] MaskCbz   = 11'b111_1111_1000;
    localparam logic [OPC_W-1:0] MatchCbz  = 11'b101_1010_0000;
    localparam logic [OPC_W-1:0] MaskB     = 11'b111_1110_0000;
    localparam logic [OPC_W-1:0] MatchB    = 11'b000_1010_0000;
    localparam logic [OPC_W-1:0] MaskImm   = 11'b111_1111_1110;
    localparam logic [OPC_W-1:0] MatchAddi = 11'b100_1000_1000;
    localparam logic [OPC_W-1:0] MatchSubi = 11'b110_1000_1000;

    typedef struct packed {
        logic             reg2loc;
        logic             alu_src;
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             uncond;
        logic [ALU_W-1:0] alu_op;
    } ctrl_t;

    function automatic logic opc_match(logic [OPC_W-1:0] opc, logic [OPC_W-1:0] mask,
                                       logic [OPC_W-1:0] match);
        return (opc & mask) == match;
    endfunction

endpackage

// File: rtl/legv8_multicycle_control_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface legv8_multicycle_control_if #(
    parameter int unsigned OPCODE_W = 11,
    parameter int unsigned ALUOP_W  = 2
);
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                reg2loc;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                uncond;
    logic [ALUOP_W-1:0]  alu_op;
    logic                ir_write;
    logic                pc_write;
    logic                instr_done;
    logic [1:0]          fault;

    modport master (
        input  run, opcode, mem_ready,
        output reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond,
        output alu_op, ir_write, pc_write, instr_done, fault
    );

    modport slave (
        output run, opcode, mem_ready,
        input  reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond,
        input  alu_op, ir_write, pc_write, instr_done, fault
    );
endinterface

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier for the multi-cycle controller.
// ADDI/SUBI are recognised only when LEGV8_IMM_OPS_EN is defined.
module legv8_opcode_class
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = OPC_W
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output opc_class_e          class_o
);
    logic [OPC_W-1:0] opc;
    assign opc = opcode_i[OPC_W-1:0];

    always_comb begin
        class_o = ClsIll;
        if (opc_match(opc, MaskR, MatchR)) begin
            class_o = ClsR;
        end else if (opc == OpcLdur) begin
            class_o = ClsLd;
        end else if (opc == OpcStur) begin
            class_o = ClsSt;
        end else if (opc_match(opc, MaskCbz, MatchCbz)) begin
            class_o = ClsCbz;
        end else if (opc_match(opc, MaskB, MatchB)) begin
            class_o = ClsB;
        end
`ifdef LEGV8_IMM_OPS_EN
        else if (opc_match(opc, MaskImm, MatchAddi) || opc_match(opc, MaskImm, MatchSubi)) begin
            class_o = ClsImm;
        end
`endif
    end
endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control FSM with bounded shared-memory waits and sticky fault.
// LEGV8_IMM_OPS_EN enables the ADDI/SUBI path through EX_I.
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 11,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    legv8_multicycle_control_if.master bus
);
    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    fault_e          fault_q, fault_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            timed_out;
    logic            waiting;
    logic            fetch_hit;
    logic            done;
    opc_class_e      opc_class;
    ctrl_t           ctrl;

    legv8_opcode_class #(
        .OPCODE_W(OPCODE_W)
    ) u_class (
        .opcode_i(bus.opcode),
        .class_o (opc_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            fault_q <= FaultNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating wait counter; timeout fires on the cycle it would reach MEM_TIMEOUT.
    assign cnt_inc   = (cnt_q == CntW'(MEM_TIMEOUT)) ? cnt_q : cnt_q + CntW'(1);
    assign timed_out = (cnt_inc == CntW'(MEM_TIMEOUT));
    assign waiting   = (state_q == StFetch) || (state_q == StMemLd) || (state_q == StMemSt);

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:   if (bus.run) state_d = StFetch;
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opc_class)
                    ClsR:         state_d = StExR;
                    ClsLd, ClsSt: state_d = StExAddr;
                    ClsCbz:       state_d = StBrCbz;
                    ClsB:         state_d = StBrB;
`ifdef LEGV8_IMM_OPS_EN
                    ClsImm:       state_d = StExI;
`endif
                    default: begin
                        state_d = StHalt;
                        fault_d = FaultIllegal;
                    end
                endcase
            end
            StExR:    state_d = StWbR;
`ifdef LEGV8_IMM_OPS_EN
            StExI:    state_d = StWbR;
`endif
            StExAddr: state_d = (opc_class == ClsLd) ? StMemLd : StMemSt;
            StMemLd:  if (bus.mem_ready) state_d = StWbLd;
            StMemSt:  if (bus.mem_ready) state_d = bus.run ? StFetch : StIdle;
            StWbR, StWbLd, StBrCbz, StBrB: state_d = bus.run ? StFetch : StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StHalt;
        endcase

        if (waiting && !bus.mem_ready) begin
            cnt_d = cnt_inc;
            if (timed_out) begin
                state_d = StHalt;
                fault_d = FaultTimeout;
            end
        end

        if (state_d != state_q &&
            (state_d == StFetch || state_d == StMemLd || state_d == StMemSt)) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        ctrl      = '0;
        fetch_hit = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StFetch: begin
                ctrl.mem_read = 1'b1;
                fetch_hit     = bus.mem_ready;
            end
            StExR:    ctrl.alu_op = AluFunct;
`ifdef LEGV8_IMM_OPS_EN
            StExI: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = AluFunct;
            end
`endif
            StExAddr: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = AluAdd;
            end
            StMemLd:  ctrl.mem_read = 1'b1;
            StMemSt: begin
                ctrl.mem_write = 1'b1;
                ctrl.reg2loc   = 1'b1;
                done           = bus.mem_ready;
            end
            StWbR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = AluFunct;
                done           = 1'b1;
            end
            StWbLd: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                done            = 1'b1;
            end
            StBrCbz: begin
                ctrl.reg2loc = 1'b1;
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = AluPassB;
                done         = 1'b1;
            end
            StBrB: begin
                ctrl.uncond = 1'b1;
                done        = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.reg2loc    = ctrl.reg2loc;
    assign bus.alu_src    = ctrl.alu_src;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.branch     = ctrl.branch;
    assign bus.uncond     = ctrl.uncond;
    assign bus.alu_op     = ALUOP_W'(ctrl.alu_op);
    assign bus.ir_write   = fetch_hit;
    assign bus.pc_write   = fetch_hit;
    assign bus.instr_done = done;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Bench for legv8_multicycle_control: instruction-level step-list model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_legv8_multicycle_control;
    localparam int MEM_TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    legv8_multicycle_control_if #(.OPCODE_W(11), .ALUOP_W(2)) bus ();

    legv8_multicycle_control #(
        .OPCODE_W   (11),
        .ALUOP_W    (2),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: each instruction is a list of named steps; outputs are a lookup on the step name.
    string    plan[$];
    bit       m_idle  = 1'b1;
    bit       m_halt  = 1'b0;
    bit [1:0] m_fault = 2'b00;
    int       m_cnt   = 0;

    // {reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond, alu_op}
    function automatic bit [9:0] step_outs(string s);
        if (s == "FETCH")   return 10'b00001_00000;
        if (s == "EX_R")    return 10'b00000_00010;
        if (s == "WB_R")    return 10'b00010_00010;
        if (s == "EX_ADDR") return 10'b01000_00000;
        if (s == "MEM_LD")  return 10'b00001_00000;
        if (s == "WB_LD")   return 10'b00110_00000;
        if (s == "MEM_ST")  return 10'b10000_10000;
        if (s == "BR_CBZ")  return 10'b10000_01001;
        if (s == "BR_B")    return 10'b00000_00100;
        if (s == "EX_I")    return 10'b01000_00010;
        return 10'b0;
    endfunction

    function automatic bit is_wait(string s);
        return s == "FETCH" || s == "MEM_LD" || s == "MEM_ST";
    endfunction

    function automatic bit is_retire(string s);
        return s == "WB_R" || s == "WB_LD" || s == "BR_CBZ" || s == "BR_B" || s == "MEM_ST";
    endfunction

    function automatic void expand(logic [10:0] op);
        if (op ==? 11'b1??0101?000) begin
            plan.push_back("EX_R");
            plan.push_back("WB_R");
        end else if (op == 11'b11111000010) begin
            plan.push_back("EX_ADDR");
            plan.push_back("MEM_LD");
            plan.push_back("WB_LD");
        end else if (op == 11'b11111000000) begin
            plan.push_back("EX_ADDR");
            plan.push_back("MEM_ST");
        end else if (op ==? 11'b10110100???) begin
            plan.push_back("BR_CBZ");
        end else if (op ==? 11'b000101?????) begin
            plan.push_back("BR_B");
        end
`ifdef LEGV8_IMM_OPS_EN
        else if (op ==? 11'b1001000100? || op ==? 11'b1101000100?) begin
            plan.push_back("EX_I");
            plan.push_back("WB_R");
        end
`endif
        else begin
            m_halt  = 1'b1;
            m_fault = 2'b01;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        string head;
        if (!rst_n) begin
            m_idle  = 1'b1;
            m_halt  = 1'b0;
            m_fault = 2'b00;
            m_cnt   = 0;
            plan.delete();
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_idle) begin
            if (bus.run) begin
                m_idle = 1'b0;
                plan.delete();
                plan.push_back("FETCH");
                m_cnt = 0;
            end
        end else begin
            head = plan[0];
            if (is_wait(head) && !bus.mem_ready) begin
                m_cnt++;
                if (m_cnt >= MEM_TIMEOUT) begin
                    m_halt  = 1'b1;
                    m_fault = 2'b10;
                end
            end else begin
                void'(plan.pop_front());
                if (head == "FETCH") plan.push_back("DECODE");
                else if (head == "DECODE") expand(bus.opcode);
                if (is_retire(head)) begin
                    if (bus.run) plan.push_back("FETCH");
                    else m_idle = 1'b1;
                end
                if (!m_halt && !m_idle && is_wait(plan[0])) m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [14:0] act;
        logic [14:0] exp;
        string       head;
        bit          live;
        live      = !m_idle && !m_halt;
        head      = live ? plan[0] : "-";
        exp[14:5] = live ? step_outs(head) : 10'b0;
        exp[4]    = live && head == "FETCH" && bus.mem_ready;
        exp[3]    = exp[4];
        exp[2]    = live && is_retire(head) && (head != "MEM_ST" || bus.mem_ready);
        exp[1:0]  = m_fault;
        act = {bus.reg2loc, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
               bus.mem_write, bus.branch, bus.uncond, bus.alu_op, bus.ir_write, bus.pc_write,
               bus.instr_done, bus.fault};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle@%0t step=%s: got %b required %b", $time, head, act, exp);
        end
    end

    task automatic check(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    int st_done_first, st_done_cnt, st_rd, st_wr, st_rw, st_rw_first, st_mtr;
    int st_br, st_r2l_br, st_unc, st_asrc, st_fault, st_last_wr, st_ctl_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; memory answers fetches at once, data after data_delay cycles.
    task automatic run_one(input logic [10:0] op, input int data_delay, input int ncyc,
                           input bit keep_run);
        bit prev_act;
        int episode;
        int wcnt;
        st_done_first = 0; st_done_cnt = 0; st_rd = 0; st_wr = 0; st_rw = 0; st_rw_first = 0;
        st_mtr = 0; st_br = 0; st_r2l_br = 0; st_unc = 0; st_asrc = 0; st_fault = 0;
        st_last_wr = 0;
        tick();
        bus.opcode    = op;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b0;
        prev_act = 1'b0;
        episode  = 0;
        wcnt     = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (!keep_run) bus.run = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
                if (!prev_act) begin
                    episode++;
                    wcnt = 0;
                end
                bus.mem_ready = (wcnt >= ((episode == 2) ? data_delay : 0));
                wcnt++;
                prev_act = 1'b1;
            end else begin
                bus.mem_ready = 1'b0;
                prev_act      = 1'b0;
            end
            @(negedge clk);
            if (bus.instr_done) begin
                st_done_cnt++;
                if (st_done_first == 0) st_done_first = c;
            end
            if (bus.reg_write) begin
                st_rw++;
                if (st_rw_first == 0) st_rw_first = c;
            end
            if (bus.mem_read) st_rd++;
            if (bus.mem_write) st_wr++;
            if (bus.mem_to_reg) st_mtr++;
            if (bus.branch) st_br++;
            if (bus.branch && bus.reg2loc) st_r2l_br++;
            if (bus.uncond) st_unc++;
            if (bus.alu_src) st_asrc++;
            st_fault   = int'(bus.fault);
            st_last_wr = int'(bus.mem_write);
        end
        tick();
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        tick();
        rst_n         = 1'b0;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total_done;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = 11'b0;
        repeat (2) @(negedge clk);
        check("reset_mem_read", int'(bus.mem_read), 0);
        check("reset_fault", int'(bus.fault), 0);
        tick();
        rst_n = 1'b1;

        // ADD, memory always ready
        run_one(11'b10001011000, 0, 8, 1'b0);
        check("add_done_cycle", st_done_first, 4);
        check("add_done_cnt", st_done_cnt, 1);
        check("add_rw_cycles", st_rw, 1);
        check("add_rw_cycle", st_rw_first, 4);
        check("add_rd_cycles", st_rd, 1);

        // LDUR, data 3 cycles late
        run_one(11'b11111000010, 3, 12, 1'b0);
        check("ldur_rd_cycles", st_rd, 5);
        check("ldur_done_cycle", st_done_first, 8);
        check("ldur_mtr", st_mtr, 1);
        check("ldur_rw", st_rw, 1);

        // LDUR, ready on the last allowed cycle
        run_one(11'b11111000010, MEM_TIMEOUT - 1, 24, 1'b0);
        check("ldur_edge_rd", st_rd, 1 + MEM_TIMEOUT);
        check("ldur_edge_done", st_done_cnt, 1);
        check("ldur_edge_fault", st_fault, 0);

        // STUR, memory never answers
        run_one(11'b11111000000, 1000, 24, 1'b0);
        check("stur_wr_cycles", st_wr, 16);
        check("stur_fault", st_fault, 2);
        check("stur_wr_final", st_last_wr, 0);
        check("stur_done", st_done_cnt, 0);
        reset_pulse();

        // Illegal opcode, then run toggling while halted
        run_one(11'b11111111111, 0, 6, 1'b0);
        check("ill_fault", st_fault, 1);
        check("ill_done", st_done_cnt, 0);
        st_ctl_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.run = (i % 2 == 0);
            @(negedge clk);
            if (bus.mem_read || bus.mem_write || bus.reg_write || bus.instr_done) st_ctl_cyc++;
        end
        check("halt_fault_sticky", int'(bus.fault), 1);
        check("halt_quiet", st_ctl_cyc, 0);
        reset_pulse();
        @(negedge clk);
        check("post_reset_fault", int'(bus.fault), 0);
        check("post_reset_idle", int'(bus.mem_read), 0);

        // CBZ then B
        run_one(11'b10110100101, 0, 6, 1'b0);
        total_done = st_done_cnt;
        check("cbz_branch", st_br, 1);
        check("cbz_reg2loc", st_r2l_br, 1);
        check("cbz_done_cycle", st_done_first, 3);
        run_one(11'b00010110000, 0, 6, 1'b0);
        total_done += st_done_cnt;
        check("b_uncond", st_unc, 1);
        check("b_done_cycle", st_done_first, 3);
        check("cbz_b_done_total", total_done, 2);

        // ADDI
        run_one(11'b10010001000, 0, 8, 1'b0);
`ifdef LEGV8_IMM_OPS_EN
        check("addi_alu_src", st_asrc, 1);
        check("addi_rw", st_rw, 1);
        check("addi_done_cycle", st_done_first, 4);
        check("addi_fault", st_fault, 0);
`else
        check("addi_fault", st_fault, 1);
        check("addi_done", st_done_cnt, 0);
`endif
        reset_pulse();

        // Back-to-back ADDs with run held; ends stalled in FETCH
        run_one(11'b10001011000, 0, 12, 1'b1);
        check("b2b_done_cnt", st_done_cnt, 3);
        @(negedge clk);
        check("stall_fetch_rd", int'(bus.mem_read), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", int'(bus.mem_read), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
